// File: rtl/fm_carrier_sequencer.sv
// fm_carrier_sequencer: applies FM adapter configuration requests, holding FM off around
// deviation-shift changes and ramping the carrier phase increment toward its target.
module fm_carrier_sequencer #(
    parameter int CARRIER_PINC_WIDTH = 32,
    parameter int STEP_WIDTH = 16,
    parameter int INTERVAL_WIDTH = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic cfg_valid,
    output logic cfg_ready,
    input  logic [CARRIER_PINC_WIDTH-1:0] cfg_pinc,
    input  logic [4:0] cfg_shift,
    input  logic cfg_fm_enable,
    input  logic [STEP_WIDTH-1:0] cfg_step,
    input  logic [INTERVAL_WIDTH-1:0] cfg_interval,
    input  logic abort,
    output logic fm_enable,
    output logic [4:0] shift_carrier,
    output logic [CARRIER_PINC_WIDTH-1:0] phase_carrier,
    output logic busy,
    output logic done
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, QUIESCE, RAMP} state_t;
    state_t state;
    logic [CARRIER_PINC_WIDTH-1:0] target, step_ext, diff, next_phase;
    logic [STEP_WIDTH-1:0] step_q;
    logic [INTERVAL_WIDTH-1:0] ival, reload, count;
    logic [SW-1:0] settle;
    logic [4:0] shift_q;
    logic fm_q, finish;
    assign cfg_ready = (state == IDLE);
    assign busy = !cfg_ready;
    assign ival = (cfg_interval == '0) ? INTERVAL_WIDTH'(1) : cfg_interval;
    assign step_ext = CARRIER_PINC_WIDTH'(step_q);
    assign diff = (target >= phase_carrier) ? target - phase_carrier : phase_carrier - target;
    assign finish = (step_q == '0) || (diff <= step_ext);
    assign next_phase = finish ? target :
                        (target > phase_carrier) ? phase_carrier + step_ext : phase_carrier - step_ext;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            fm_enable <= 1'b0;
            shift_carrier <= '0;
            phase_carrier <= '0;
            done <= 1'b0;
            target <= '0;
            step_q <= '0;
            shift_q <= '0;
            fm_q <= 1'b0;
            reload <= '0;
            count <= '0;
            settle <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    target <= cfg_pinc;
                    shift_q <= cfg_shift;
                    fm_q <= cfg_fm_enable;
                    step_q <= cfg_step;
                    reload <= ival - INTERVAL_WIDTH'(1);
                    if (cfg_shift != shift_carrier) begin
                        state <= QUIESCE;
                        fm_enable <= 1'b0;
                        settle <= SW'(SETTLE_CYCLES - 1);
                    end else begin
                        // one extra count covers the cycle spent latching the request
                        state <= RAMP;
                        count <= ival;
                    end
                end
                QUIESCE: if (abort) begin
                    state <= IDLE;
                    fm_enable <= 1'b0;
                end else if (settle == '0) begin
                    shift_carrier <= shift_q;
                    state <= RAMP;
                    count <= reload;
                end else begin
                    settle <= settle - SW'(1);
                end
                RAMP: if (abort) begin
                    state <= IDLE;
                    fm_enable <= 1'b0;
                end else if (count == '0) begin
                    phase_carrier <= next_phase;
                    count <= reload;
                    if (finish) begin
                        fm_enable <= fm_q;
                        done <= 1'b1;
                        state <= IDLE;
                    end
                end else begin
                    count <= count - INTERVAL_WIDTH'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fm_carrier_sequencer.sv
// tb_fm_carrier_sequencer: directed scenarios plus randomized requests against a trajectory model.
module tb_fm_carrier_sequencer;
    localparam int SETTLE = 4;
    logic aclk = 1'b0, aresetn = 1'b0, cfg_valid = 1'b0, cfg_fm_enable = 1'b0, abort = 1'b0;
    logic [31:0] cfg_pinc = '0;
    logic [4:0] cfg_shift = '0;
    logic [15:0] cfg_step = '0, cfg_interval = '0;
    logic cfg_ready, fm_enable, busy, done;
    logic [4:0] shift_carrier;
    logic [31:0] phase_carrier;
    int total = 0, bad = 0;

    fm_carrier_sequencer #(.CARRIER_PINC_WIDTH(32), .STEP_WIDTH(16), .INTERVAL_WIDTH(16),
                           .SETTLE_CYCLES(SETTLE)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pinc(cfg_pinc), .cfg_shift(cfg_shift), .cfg_fm_enable(cfg_fm_enable),
        .cfg_step(cfg_step), .cfg_interval(cfg_interval), .abort(abort),
        .fm_enable(fm_enable), .shift_carrier(shift_carrier), .phase_carrier(phase_carrier),
        .busy(busy), .done(done)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic [4:0] s, input logic f,
                        input logic [15:0] st, input logic [15:0] iv);
        cfg_pinc = p; cfg_shift = s; cfg_fm_enable = f; cfg_step = st; cfg_interval = iv;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #12;
        total++; if (fm_enable !== 1'b0) begin bad++; $display("FAIL reset_fm got=%0b exp=0", fm_enable); end
        total++; if (shift_carrier !== 5'd0) begin bad++; $display("FAIL reset_shift got=%0d exp=0", shift_carrier); end
        total++; if (phase_carrier !== 32'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase_carrier); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cfg_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        aresetn = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_jump();
        send(32'd1000, 5'd0, 1'b1, 16'd0, 16'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL jump_busy got=%0b exp=1", busy); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL jump_ready got=%0b exp=0", cfg_ready); end
        tick();
        total++; if (phase_carrier !== 32'd0) begin bad++; $display("FAIL jump_phase_k1 got=%0d exp=0", phase_carrier); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL jump_done_k1 got=%0b exp=0", done); end
        tick();
        total++; if (phase_carrier !== 32'd1000) begin bad++; $display("FAIL jump_phase got=%0d exp=1000", phase_carrier); end
        total++; if (fm_enable !== 1'b1) begin bad++; $display("FAIL jump_fm got=%0b exp=1", fm_enable); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL jump_done got=%0b exp=1", done); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL jump_ready_end got=%0b exp=1", cfg_ready); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL jump_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_up_ramp();
        int exp_p[9] = '{1000, 1000, 1100, 1100, 1200, 1200, 1300, 1300, 1350};
        send(32'd1350, 5'd0, 1'b1, 16'd100, 16'd2);
        for (int i = 0; i < 9; i++) begin
            tick();
            total++; if (phase_carrier !== 32'(exp_p[i])) begin bad++; $display("FAIL up_phase k+%0d got=%0d exp=%0d", i + 1, phase_carrier, exp_p[i]); end
            total++; if (done !== (i == 8)) begin bad++; $display("FAIL up_done k+%0d got=%0b exp=%0b", i + 1, done, i == 8); end
        end
    endtask

    task automatic test_down_ramp();
        int exp_p[3] = '{1350, 1150, 1000};
        send(32'd1000, 5'd0, 1'b1, 16'd200, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (phase_carrier !== 32'(exp_p[i])) begin bad++; $display("FAIL down_phase k+%0d got=%0d exp=%0d", i + 1, phase_carrier, exp_p[i]); end
            total++; if (done !== (i == 2)) begin bad++; $display("FAIL down_done k+%0d got=%0b exp=%0b", i + 1, done, i == 2); end
        end
    endtask

    task automatic test_shift_change();
        send(32'd1000, 5'd3, 1'b1, 16'd0, 16'd1);
        total++; if (fm_enable !== 1'b0) begin bad++; $display("FAIL shift_fm_k got=%0b exp=0", fm_enable); end
        total++; if (shift_carrier !== 5'd0) begin bad++; $display("FAIL shift_k got=%0d exp=0", shift_carrier); end
        for (int t = 1; t <= 5; t++) begin
            tick();
            total++; if (shift_carrier !== ((t >= SETTLE) ? 5'd3 : 5'd0)) begin bad++; $display("FAIL shift_val k+%0d got=%0d", t, shift_carrier); end
            total++; if (fm_enable !== (t == 5)) begin bad++; $display("FAIL shift_fm k+%0d got=%0b exp=%0b", t, fm_enable, t == 5); end
            total++; if (done !== (t == 5)) begin bad++; $display("FAIL shift_done k+%0d got=%0b exp=%0b", t, done, t == 5); end
        end
        total++; if (phase_carrier !== 32'd1000) begin bad++; $display("FAIL shift_phase got=%0d exp=1000", phase_carrier); end
    endtask

    task automatic test_abort();
        send(32'd1350, 5'd3, 1'b1, 16'd100, 16'd2);
        repeat (5) tick();
        total++; if (phase_carrier !== 32'd1200) begin bad++; $display("FAIL abort_pre_phase got=%0d exp=1200", phase_carrier); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        total++; if (fm_enable !== 1'b0) begin bad++; $display("FAIL abort_fm got=%0b exp=0", fm_enable); end
        total++; if (phase_carrier !== 32'd1200) begin bad++; $display("FAIL abort_phase got=%0d exp=1200", phase_carrier); end
        total++; if (shift_carrier !== 5'd3) begin bad++; $display("FAIL abort_shift got=%0d exp=3", shift_carrier); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b exp=0", done); end
        send(32'd1200, 5'd3, 1'b1, 16'd0, 16'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_reaccept got=%0b exp=1", busy); end
        repeat (2) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_next_done got=%0b exp=1", done); end
        total++; if (fm_enable !== 1'b1) begin bad++; $display("FAIL abort_next_fm got=%0b exp=1", fm_enable); end
    endtask

    task automatic test_handshake();
        int exp_p[4] = '{1200, 1300, 1400, 1500};
        send(32'd1500, 5'd3, 1'b1, 16'd100, 16'd1);
        cfg_pinc = 32'd1600; cfg_fm_enable = 1'b0; cfg_step = 16'd0; cfg_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (phase_carrier !== 32'(exp_p[i])) begin bad++; $display("FAIL hs_phase k+%0d got=%0d exp=%0d", i + 1, phase_carrier, exp_p[i]); end
            total++; if (done !== (i == 3)) begin bad++; $display("FAIL hs_done k+%0d got=%0b exp=%0b", i + 1, done, i == 3); end
        end
        tick();
        cfg_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hs_second_accept got=%0b exp=1", busy); end
        repeat (2) tick();
        total++; if (phase_carrier !== 32'd1600) begin bad++; $display("FAIL hs_second_phase got=%0d exp=1600", phase_carrier); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL hs_second_done got=%0b exp=1", done); end
        total++; if (fm_enable !== 1'b0) begin bad++; $display("FAIL hs_second_fm got=%0b exp=0", fm_enable); end
        repeat (3) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hs_once got=%0b exp=0", busy); end
        abort = 1'b1;
        send(32'd1700, 5'd3, 1'b1, 16'd0, 16'd1);
        abort = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL idle_abort_accept got=%0b exp=1", busy); end
        repeat (2) tick();
        total++; if (phase_carrier !== 32'd1700) begin bad++; $display("FAIL idle_abort_phase got=%0d exp=1700", phase_carrier); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL idle_abort_done got=%0b exp=1", done); end
    endtask

    task automatic test_async_reset();
        send(32'd5000, 5'd3, 1'b1, 16'd10, 16'd3);
        repeat (3) tick();
        #2 aresetn = 1'b0;
        #1;
        total++; if (fm_enable !== 1'b0) begin bad++; $display("FAIL areset_fm got=%0b exp=0", fm_enable); end
        total++; if (shift_carrier !== 5'd0) begin bad++; $display("FAIL areset_shift got=%0d exp=0", shift_carrier); end
        total++; if (phase_carrier !== 32'd0) begin bad++; $display("FAIL areset_phase got=%0d exp=0", phase_carrier); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%0b exp=1", cfg_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done got=%0b exp=0", done); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        longint p = 0, tgt, st, iv, first, diff, n, done_t, u, ep;
        logic [4:0] s = 5'd0, sh, es;
        logic f = 1'b0, fe, qs, efm;
        logic [15:0] ivl;
        for (int it = 0; it < 25; it++) begin
            tgt = longint'($urandom_range(0, 20000));
            sh = 5'($urandom_range(0, 3));
            fe = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(200, 3000));
            ivl = 16'($urandom_range(0, 3));
            iv = (ivl == 0) ? 1 : longint'(ivl);
            qs = (sh != s);
            first = qs ? SETTLE + iv : iv + 1;
            diff = (tgt >= p) ? tgt - p : p - tgt;
            n = (st == 0 || diff <= st) ? 1 : (diff + st - 1) / st;
            done_t = first + (n - 1) * iv;
            send(32'(tgt), sh, fe, 16'(st), ivl);
            for (longint t = 0; t <= done_t; t++) begin
                if (t > 0) tick();
                u = (t < first) ? 0 : (t - first) / iv + 1;
                ep = (u >= n) ? tgt : (tgt > p) ? p + u * st : p - u * st;
                es = (qs && t >= SETTLE) ? sh : s;
                efm = (t == done_t) ? fe : (qs ? 1'b0 : f);
                total++; if (phase_carrier !== 32'(ep)) begin bad++; $display("FAIL rnd_phase it=%0d t=%0d got=%0d exp=%0d", it, t, phase_carrier, ep); end
                total++; if (shift_carrier !== es) begin bad++; $display("FAIL rnd_shift it=%0d t=%0d got=%0d exp=%0d", it, t, shift_carrier, es); end
                total++; if (fm_enable !== efm) begin bad++; $display("FAIL rnd_fm it=%0d t=%0d got=%0b exp=%0b", it, t, fm_enable, efm); end
                total++; if (done !== (t == done_t)) begin bad++; $display("FAIL rnd_done it=%0d t=%0d got=%0b exp=%0b", it, t, done, t == done_t); end
                total++; if (busy !== (t < done_t)) begin bad++; $display("FAIL rnd_busy it=%0d t=%0d got=%0b exp=%0b", it, t, busy, t < done_t); end
            end
            p = tgt; s = sh; f = fe;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_up_ramp();
        test_down_ramp();
        test_shift_change();
        test_abort();
        test_handshake();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
